bcd_display_driver: RTL and testbench
=====================================

// Module: bcd_display_driver
// PURPOSE
//  Sits directly downstream of decade_counter: consumes its count (ones digit) and ten (carry).
//  Extends the count to a 4-digit BCD value (ones..thousands).
//  Drives a time-multiplexed 4-digit common-anode seven-segment display; exposes the BCD value for checking.
// PARAMETERS
//  REFRESH_DIV     50000  clk cycles each digit is lit before the scan advances; legal range >= 2
//  SEG_ACTIVE_LOW  1      1: seg drives 0 = segment on; 0: seg drives 1 = segment on
//  BLANK_LEADING   1      1: unlit leading-zero digits above digit 0; 0: show all digits
// PORTS
//  clk       in   1   system clock, rising edge
//  rst       in   1   synchronous reset, active-high
//  count     in   4   ones digit from decade_counter
//  ten       in   1   carry from decade_counter; 1-cycle pulse while count==9
//  seg       out  7   {g,f,e,d,c,b,a} segment drive, polarity per SEG_ACTIVE_LOW
//  an        out  4   digit enables, active-low one-hot; an[0] = ones
//  value     out  16  {thousands,hundreds,tens,ones} BCD
//  overflow  out  1   sticky flag, set on 9999->0000 wrap
// BEHAVIOUR
//  - Reset: all registers are synchronous; rst has priority over every other input.
//  - Reset values: d1=d2=d3=0, count_q=0, refresh_cnt=0, scan_idx=0, an=4'b1111.
//    seg is all segments off (7'h7F if active-low, 7'h00 if active-high). value=0. overflow=0.
//  - count_q <= count on every edge; ones digit = count_q (1-cycle lag).
//  - Digit cascade, evaluated on each edge where ten=1 (d1=tens, d2=hundreds, d3=thousands):
//    - d1 increments; if d1==9, d1 <= 0 and the carry passes to d2.
//    - d2 and d3 follow the same rule in turn.
//    - If d1=d2=d3=9, all three go to 0 and overflow <= 1.
//  - overflow is cleared only by rst.
//  - ten is not qualified by count; each pulse is exactly one increment.
//  - A ten held high for N cycles gives N increments.
//  - value = {d3,d2,d1,count_q}, registered, no further latency.
//  - Refresh:
//    - refresh_cnt counts 0..REFRESH_DIV-1, then wraps to 0.
//    - On the wrap edge, scan_idx advances 0->1->2->3->0.
//    - refresh_cnt width = $clog2(REFRESH_DIV).
//  - Display registers: an and seg are updated together on every non-reset edge from current state.
//    - an <= ~(4'b0001 << scan_idx).
//    - seg <= decode(digit[scan_idx]).
//    - The first edge after rst falls gives an=4'b1110.
//  - Decode table (active-high {g..a}; inverted when SEG_ACTIVE_LOW=1):
//    0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
//    Ones digit 10..15 shows 'E' = 79 (active-low 06). d1..d3 cannot exceed 9.
//  - Blanking: with BLANK_LEADING=1, digit k (k=1..3) is blanked when it and all higher digits are 0.
//    A blanked digit keeps its an line active and drives seg to all-off.
//    Digit 0 is never blanked.
//  - Reset mid-scan or mid-cascade: state returns to reset values on that edge.
//    Scanning restarts at digit 0 with a full REFRESH_DIV period.
// TESTING (bench: REFRESH_DIV=4, SEG_ACTIVE_LOW=1, BLANK_LEADING=1, 20 ns clk)
//  1. rst=1 for 3 cycles, count=5, ten=1
//     -> an=4'b1111, seg=7'h7F, value=16'h0000, overflow=0; no increment.
//  2. Release rst; count steps 0..9 with ten=1 at count 9, then count=0
//     -> value=16'h0010 two edges after the pulse; an=4'b1110 after the first edge.
//  3. Scan check -> an holds each code for 4 cycles, in the order 1110,1101,1011,0111, then back to 1110.
//  4. Apply 999 ten pulses, then 1 more -> value[15:4]=12'h999, then 12'h000 with overflow=1.
//     Further pulses leave overflow=1; rst clears it.
//  5. value=16'h0105, checked per digit:
//     - an=0111 -> seg=7'h7F (blank)
//     - an=1011 -> seg=7'h79 ('1')
//     - an=1101 -> seg=7'h40 ('0', not blanked)
//     - an=1110 -> seg=7'h12 ('5')
//  6. count=4'hC -> seg=7'h06 ('E') while an=1110.
//     Then rst=1 with scan_idx=2 and ten=1 -> next edge gives all reset values; ten is ignored.

Source files
------------

// File: rtl/bcd_display_driver.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_display_driver
//  Description : Extends a decade_counter ones digit (count) and its carry
//                pulse (ten) into a 4-digit BCD value, and scans that value
//                onto a 4-digit common-anode seven-segment display.
//  Ports       : clk      - system clock, rising edge
//                rst      - synchronous reset, active-high
//                count    - ones digit from decade_counter
//                ten      - carry pulse from decade_counter (one increment
//                           of the tens digit per cycle it is high)
//                seg      - {g,f,e,d,c,b,a} segment drive
//                an       - active-low one-hot digit enables, an[0] = ones
//                value    - {thousands,hundreds,tens,ones} BCD
//                overflow - sticky, set when 9999 wraps to 0000
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_driver #(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  count,
    input  logic        ten,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic [15:0] value,
    output logic        overflow
);

    localparam int                 c_CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]         c_SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [3:0]         r_count_q;
    logic [3:0]         r_d1;
    logic [3:0]         r_d2;
    logic [3:0]         r_d3;
    logic               r_overflow;
    logic [c_CNT_W-1:0] r_refresh;
    logic [1:0]         r_scan_idx;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;

    logic [3:0]         w_digit;
    logic               w_blank;
    logic [6:0]         w_seg_on;
    logic [6:0]         w_seg_next;

    // Active-high {g..a} pattern; the ones digit may carry 10..15 from
    // upstream and those all show 'E'.
    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h79;
        endcase
        return p;
    endfunction

    // Select the digit being scanned and decide whether it is a leading zero.
    always_comb begin
        w_digit = r_count_q;
        w_blank = 1'b0;
        case (r_scan_idx)
            2'd0: begin
                w_digit = r_count_q;
            end
            2'd1: begin
                w_digit = r_d1;
                w_blank = (r_d3 == 4'd0) && (r_d2 == 4'd0) && (r_d1 == 4'd0);
            end
            2'd2: begin
                w_digit = r_d2;
                w_blank = (r_d3 == 4'd0) && (r_d2 == 4'd0);
            end
            default: begin
                w_digit = r_d3;
                w_blank = (r_d3 == 4'd0);
            end
        endcase
        if (!BLANK_LEADING) begin
            w_blank = 1'b0;
        end
    end

    assign w_seg_on   = w_blank ? 7'h00 : f_decode(w_digit);
    assign w_seg_next = SEG_ACTIVE_LOW ? ~w_seg_on : w_seg_on;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q  <= 4'd0;
            r_d1       <= 4'd0;
            r_d2       <= 4'd0;
            r_d3       <= 4'd0;
            r_overflow <= 1'b0;
            r_refresh  <= '0;
            r_scan_idx <= 2'd0;
            r_an       <= 4'b1111;
            r_seg      <= c_SEG_OFF;
        end else begin
            r_count_q <= count;

            // Ripple the carry through tens, hundreds, thousands.
            if (ten) begin
                if (r_d1 != 4'd9) begin
                    r_d1 <= r_d1 + 4'd1;
                end else begin
                    r_d1 <= 4'd0;
                    if (r_d2 != 4'd9) begin
                        r_d2 <= r_d2 + 4'd1;
                    end else begin
                        r_d2 <= 4'd0;
                        if (r_d3 != 4'd9) begin
                            r_d3 <= r_d3 + 4'd1;
                        end else begin
                            r_d3       <= 4'd0;
                            r_overflow <= 1'b1;
                        end
                    end
                end
            end

            if (r_refresh == c_CNT_LAST) begin
                r_refresh  <= '0;
                r_scan_idx <= r_scan_idx + 2'd1;
            end else begin
                r_refresh  <= r_refresh + 1'b1;
            end

            // Enables and segments are both taken from the pre-edge scan
            // index so they always describe the same digit.
            r_an  <= ~(4'b0001 << r_scan_idx);
            r_seg <= w_seg_next;
        end
    end

    assign seg      = r_seg;
    assign an       = r_an;
    assign value    = {r_d3, r_d2, r_d1, r_count_q};
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_display_driver
//  Description : Self-checking bench for bcd_display_driver (REFRESH_DIV=4,
//                active-low segments, leading-zero blanking). An arithmetic
//                reference model tracks the displayed number as an integer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_display_driver;

    localparam int c_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  count = 4'd0;
    logic        ten = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] value;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int         m_upper;     // tens..thousands as a plain integer 0..999
    logic [3:0] m_ones;
    logic       m_ovf;
    int         m_edges;     // non-reset edges since the last reset
    logic [3:0] m_an;
    logic [6:0] m_seg;

    // Active-high glyphs for 0..15 (10..15 show 'E')
    logic [6:0] glyph [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h79, 7'h79,
                                 7'h79, 7'h79, 7'h79, 7'h79};

    typedef struct {
        logic [3:0] cnt;
        logic [6:0] seg;
    } vec_t;
    vec_t vecs [0:15];

    logic [3:0] scan_codes [0:4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    bcd_display_driver #(
        .REFRESH_DIV    (c_DIV),
        .SEG_ACTIVE_LOW (1'b1),
        .BLANK_LEADING  (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .count    (count),
        .ten      (ten),
        .seg      (seg),
        .an       (an),
        .value    (value),
        .overflow (overflow)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model, and compare every output.
    task automatic cycle(input logic r, input logic [3:0] c, input logic t);
        int         scan;
        int         dig;
        logic       blank;
        logic [15:0] exp_val;
        rst   = r;
        count = c;
        ten   = t;
        if (r) begin
            m_upper = 0;
            m_ones  = 4'd0;
            m_ovf   = 1'b0;
            m_edges = 0;
            m_an    = 4'b1111;
            m_seg   = 7'h7F;
        end else begin
            scan = (m_edges / c_DIV) % 4;
            m_an = 4'(~(4'b0001 << scan));
            case (scan)
                0:       begin dig = int'(m_ones);       blank = 1'b0;            end
                1:       begin dig = m_upper % 10;       blank = (m_upper == 0);  end
                2:       begin dig = (m_upper / 10) % 10; blank = (m_upper < 10); end
                default: begin dig = m_upper / 100;      blank = (m_upper < 100); end
            endcase
            m_seg  = blank ? 7'h7F : ~glyph[dig];
            m_ones = c;
            if (t) begin
                m_upper++;
                if (m_upper == 1000) begin
                    m_upper = 0;
                    m_ovf   = 1'b1;
                end
            end
            m_edges++;
        end
        @(posedge clk);
        #1;
        exp_val = {4'(m_upper / 100), 4'((m_upper / 10) % 10), 4'(m_upper % 10), m_ones};
        check("model_value",    value,           exp_val);
        check("model_overflow", 16'(overflow),   16'(m_ovf));
        check("model_an",       16'(an),         16'(m_an));
        check("model_seg",      16'(seg),        16'(m_seg));
    endtask

    initial begin
        bit   seen;
        logic r;
        logic t;

        for (int i = 0; i < 16; i++) begin
            vecs[i].cnt = 4'(i);
        end
        vecs[0].seg  = 7'h40; vecs[1].seg  = 7'h79; vecs[2].seg  = 7'h24;
        vecs[3].seg  = 7'h30; vecs[4].seg  = 7'h19; vecs[5].seg  = 7'h12;
        vecs[6].seg  = 7'h02; vecs[7].seg  = 7'h78; vecs[8].seg  = 7'h00;
        vecs[9].seg  = 7'h10;
        for (int i = 10; i < 16; i++) vecs[i].seg = 7'h06;

        // Reset held with stimulus active: nothing may move.
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'd5, 1'b1);
        check("rst_an",       16'(an),       16'h000F);
        check("rst_seg",      16'(seg),      16'h007F);
        check("rst_value",    value,         16'h0000);
        check("rst_overflow", 16'(overflow), 16'h0000);

        // Release reset, count 0..9 with a carry at 9, then 0.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 4'(i), (i == 9));
            if (i == 0) check("first_an", 16'(an), 16'h000E);
        end
        cycle(1'b0, 4'd0, 1'b0);
        check("carry_value", value, 16'h0010);

        // Scan order and dwell from a fresh reset.
        cycle(1'b1, 4'd0, 1'b0);
        for (int n = 0; n < 20; n++) begin
            cycle(1'b0, 4'd0, 1'b0);
            check("scan_an", 16'(an), 16'(scan_codes[n / 4]));
        end

        // Full cascade and 9999 -> 0000 wrap.
        cycle(1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 999; i++) cycle(1'b0, 4'd0, 1'b1);
        check("pre_wrap_upper", 16'(value[15:4]), 16'h0999);
        check("pre_wrap_ovf",   16'(overflow),    16'h0000);
        cycle(1'b0, 4'd0, 1'b1);
        check("wrap_upper", 16'(value[15:4]), 16'h0000);
        check("wrap_ovf",   16'(overflow),    16'h0001);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0, 1'b1);
        check("sticky_ovf", 16'(overflow), 16'h0001);
        cycle(1'b1, 4'd0, 1'b0);
        check("rst_clears_ovf", 16'(overflow), 16'h0000);

        // Digit decode with the ones digit on display (table-driven).
        foreach (vecs[i]) begin
            cycle(1'b1, vecs[i].cnt, 1'b0);
            cycle(1'b0, vecs[i].cnt, 1'b0);
            cycle(1'b0, vecs[i].cnt, 1'b0);
            check("tbl_an",  16'(an),  16'h000E);
            check("tbl_seg", 16'(seg), 16'(vecs[i].seg));
        end

        // 0105: thousands blanked, embedded zero shown.
        cycle(1'b1, 4'd5, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 4'd5, 1'b1);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 4'd5, 1'b0);
            case (an)
                4'b0111: check("d3_blank", 16'(seg), 16'h007F);
                4'b1011: check("d2_one",   16'(seg), 16'h0079);
                4'b1101: check("d1_zero",  16'(seg), 16'h0040);
                4'b1110: check("d0_five",  16'(seg), 16'h0012);
                default: check("an_onehot", 16'(an), 16'h000E);
            endcase
        end
        check("value_0105", value, 16'h0105);

        // Out-of-range ones digit shows 'E'.
        seen = 1'b0;
        cycle(1'b0, 4'hC, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 4'hC, 1'b0);
            if (an == 4'b1110 && !seen) begin
                check("e_glyph", 16'(seg), 16'h0006);
                seen = 1'b1;
            end
        end
        if (!seen) check("e_seen", 16'(seen), 16'h0001);

        // Reset mid-scan (scan index 2) with a carry pending.
        for (int i = 0; i < 16 && ((m_edges / c_DIV) % 4) != 2; i++) cycle(1'b0, 4'hC, 1'b0);
        check("reach_scan2", 16'((m_edges / c_DIV) % 4), 16'h0002);
        cycle(1'b1, 4'd3, 1'b1);
        check("midrst_an",    16'(an),       16'h000F);
        check("midrst_seg",   16'(seg),      16'h007F);
        check("midrst_value", value,         16'h0000);
        check("midrst_ovf",   16'(overflow), 16'h0000);
        cycle(1'b0, 4'd3, 1'b0);
        check("restart_an", 16'(an), 16'h000E);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 59) == 0);
            t = ($urandom_range(0, 2) == 0);
            cycle(r, 4'($urandom_range(0, 15)), t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
